// File: rtl/fp_acc_arbiter.sv
// Round-robin arbiter that time-shares one fp32 accumulator among several
// burst requesters, drains the accumulator latency and returns tagged sums.
module fp_acc_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int ACC_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           acc_ax,
  output logic                  acc_ena,
  output logic                  acc_clr,
  input  logic [31:0]           acc_result,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CNT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, OUTPUT, CLEAR} state_t;

  state_t              state_reg;
  logic [ID_WIDTH-1:0] rr_ptr_reg;
  logic [ID_WIDTH-1:0] grant_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                out_valid_reg;
  logic [31:0]         out_data_reg;
  logic [ID_WIDTH-1:0] out_id_reg;

  logic [31:0]         beat_data [NUM_REQ];
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                any_valid;
  logic                granted_valid;
  logic                in_accum;
  int                  scan_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign beat_data[gi] = req_data[32*gi +: 32];
  end

  // Scan from the far end back towards rr_ptr so the closest valid requester wins.
  always_comb begin
    pick      = rr_ptr_reg;
    any_valid = 1'b0;
    scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (req_valid[scan_idx]) begin
        pick      = ID_WIDTH'(scan_idx);
        any_valid = 1'b1;
      end
    end
  end

  assign in_accum      = (state_reg == ACCUM);
  assign granted_valid = req_valid[grant_reg];
  assign next_ptr      = (grant_reg == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

  always_comb begin
    req_ready = '0;
    if (in_accum && !rst) req_ready[grant_reg] = 1'b1;
  end

  assign acc_ax    = in_accum ? beat_data[grant_reg] : 32'h0;
  assign acc_ena   = in_accum && granted_valid && !rst;
  assign acc_clr   = rst || (state_reg == CLEAR);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_reg <= pick;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          if (granted_valid && req_last[grant_reg]) begin
            cnt_reg   <= CNT_W'(ACC_LATENCY - 1);
            state_reg <= DRAIN;
          end
        end
        // Final beat is in flight inside the accumulator; sample once it settles.
        DRAIN: begin
          if (cnt_reg == '0) begin
            out_data_reg  <= acc_result;
            out_id_reg    <= grant_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= OUTPUT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          rr_ptr_reg <= next_ptr;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc_arbiter.sv
// Scoreboard bench for fp_acc_arbiter: directed bursts feed a behavioural
// 3-cycle fp32 accumulator; a monitor pops expected (sum, id) on each result.
module tb_fp_acc_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [32*N-1:0] req_data;
  logic [31:0]     acc_ax, acc_result, out_data;
  logic            acc_ena, acc_clr, out_valid, out_ready, busy;
  logic [1:0]      out_id;

  always #5 clk = ~clk;

  fp_acc_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .ACC_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .acc_ax(acc_ax), .acc_ena(acc_ena), .acc_clr(acc_clr), .acc_result(acc_result),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .busy(busy)
  );

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic s;
    int   e;
    real  a;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Accumulator: sum register plus two delay stages gives a 3-cycle latency.
  logic [31:0] acc_sum, acc_d1, acc_d2;
  always @(posedge clk) begin
    if (acc_clr)      acc_sum <= 32'h0;
    else if (acc_ena) acc_sum <= r2f(f2r(acc_sum) + f2r(acc_ax));
    acc_d1 <= acc_sum;
    acc_d2 <= acc_d1;
  end
  assign acc_result = acc_d2;

  typedef struct {logic [31:0] data; logic last; int gap;} beat_t;
  typedef struct {logic [31:0] data; logic [1:0] id;} exp_t;

  beat_t beat_q [N][$];
  exp_t  exp_q[$];

  int compared = 0, mismatched = 0;
  int cyc_now = 0, last_cyc = 0, ov_cyc = 0, hs_cyc = 0, clr_cyc = 0;
  int hs_total = 0, clr_cnt = 0, ena_cnt = 0, stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push_beat(input int r, input logic [31:0] d, input logic l, input int g);
    beat_t b;
    b.data = d; b.last = l; b.gap = g;
    beat_q[r].push_back(b);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] id);
    exp_t e;
    e.data = d; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_total < target && n < 400) begin sample(); n++; end
    check("result_count", hs_total, target);
    repeat (3) sample();
  endtask

  // Requester driver: each beat waits out its gap, then stays valid until accepted.
  initial begin : driver
    beat_t        cur [N];
    bit           have [N];
    int           gap_left [N];
    logic [N-1:0] hs;
    logic         rs;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin have[i] = 0; gap_left[i] = 0; end
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      rs = rst;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rs) begin beat_q[i].delete(); have[i] = 0; end
        else if (hs[i]) have[i] = 0;
        if (!have[i] && beat_q[i].size() > 0) begin
          cur[i] = beat_q[i].pop_front(); have[i] = 1; gap_left[i] = cur[i].gap;
        end
        if (have[i] && gap_left[i] > 0) begin gap_left[i]--; req_valid[i] = 1'b0; end
        else req_valid[i] = have[i];
        req_data[32*i +: 32] = have[i] ? cur[i].data : 32'h0;
        req_last[i]          = have[i] & cur[i].last;
      end
    end
  end

  initial begin : monitor
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      cyc_now++;
      if ((req_valid & req_ready & req_last) != '0) last_cyc = cyc_now;
      if (out_valid && !prev_ov) ov_cyc = cyc_now;
      prev_ov = out_valid;
      if (acc_clr && !rst) begin clr_cnt++; clr_cyc = cyc_now; end
      if (acc_ena) ena_cnt++;
      if (busy && (req_ready & ~req_valid) != '0) stall_cnt++;
      if (out_valid && out_ready) begin
        hs_cyc = cyc_now;
        hs_total++;
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_result: got id=%0d data=%h, want none", out_id, out_data);
        end else begin
          e = exp_q.pop_front();
          $display("result id=%0d data=%h (expected id=%0d data=%h)", out_id, out_data, e.id, e.data);
          check("out_data", out_data, e.data);
          check("out_id", 32'(out_id), 32'(e.id));
        end
      end
    end
  end

  initial begin : stim
    int hs_target, c0, e0, s0, n, h;
    logic [31:0] hold_d;
    logic [1:0]  hold_id;
    bit ok_rdy, ok_stable, ok_clr, ok_ov;

    rst = 1'b1; out_ready = 1'b1; hs_target = 0;
    repeat (2) tick();
    sample();
    check("rst_acc_clr", 32'(acc_clr), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick(); rst = 1'b0;
    sample();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_data", out_data, 32'h0);
    check("idle_out_id", 32'(out_id), 32'd0);
    check("idle_acc_clr", 32'(acc_clr), 32'd0);
    check("idle_acc_ax", acc_ax, 32'h0);

    // Requester 1: 1 + 2 + 3 = 6.0
    tick();
    c0 = clr_cnt;
    push_beat(1, 32'h3F800000, 1'b0, 0);
    push_beat(1, 32'h40000000, 1'b0, 0);
    push_beat(1, 32'h40400000, 1'b1, 0);
    push_exp(32'h40C00000, 2'd1);
    hs_target += 1; wait_hs(hs_target);
    check("s1_latency", ov_cyc - last_cyc, 32'd4);
    check("s1_clr_after_hs", clr_cyc - hs_cyc, 32'd1);
    check("s1_clr_pulses", clr_cnt - c0, 32'd1);

    // Requesters 0 and 2 from reset, 2-beat bursts of 1.0
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    push_beat(0, 32'h3F800000, 1'b0, 0); push_beat(0, 32'h3F800000, 1'b1, 0);
    push_beat(2, 32'h3F800000, 1'b0, 0); push_beat(2, 32'h3F800000, 1'b1, 0);
    push_exp(32'h40000000, 2'd0); push_exp(32'h40000000, 2'd2);
    ok_rdy = 1; n = 0;
    while (hs_total < hs_target + 1 && n < 100) begin
      sample(); n++;
      if (req_ready[2]) ok_rdy = 0;
    end
    check("s2_no_ready2_during_first", 32'(ok_rdy), 32'd1);
    hs_target += 2; wait_hs(hs_target);

    // All four requesters, two single-beat bursts of 4.0 each
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < N; r++) begin
      push_beat(r, 32'h40800000, 1'b1, 0);
      push_beat(r, 32'h40800000, 1'b1, 0);
    end
    for (int k = 0; k < 8; k++) push_exp(32'h40800000, 2'(k % 4));
    hs_target += 8; wait_hs(hs_target);

    // Requester 3 with a 5-cycle valid gap mid-burst
    tick();
    e0 = ena_cnt; s0 = stall_cnt;
    push_beat(3, 32'h3F800000, 1'b0, 0);
    push_beat(3, 32'h3F800000, 1'b1, 5);
    push_exp(32'h40000000, 2'd3);
    hs_target += 1; wait_hs(hs_target);
    check("s4_ena_cycles", ena_cnt - e0, 32'd2);
    check("s4_gap_cycles", stall_cnt - s0, 32'd5);

    // Output back-pressure with requester 1 waiting
    tick(); out_ready = 1'b0;
    push_beat(1, 32'h40000000, 1'b1, 0);
    push_beat(1, 32'h40400000, 1'b1, 0);
    push_exp(32'h40000000, 2'd1); push_exp(32'h40400000, 2'd1);
    n = 0;
    while (!out_valid && n < 50) begin sample(); n++; end
    check("s5_out_valid_seen", 32'(out_valid), 32'd1);
    hold_d = out_data; hold_id = out_id;
    ok_rdy = 1; ok_stable = 1; ok_clr = 1; ok_ov = 1;
    for (int k = 0; k < 10; k++) begin
      if (req_ready != '0) ok_rdy = 0;
      if (out_data !== hold_d || out_id !== hold_id) ok_stable = 0;
      if (acc_clr) ok_clr = 0;
      if (!out_valid) ok_ov = 0;
      if (k < 9) sample();
    end
    check("s5_ready_low", 32'(ok_rdy), 32'd1);
    check("s5_out_stable", 32'(ok_stable), 32'd1);
    check("s5_clr_low", 32'(ok_clr), 32'd1);
    check("s5_valid_held", 32'(ok_ov), 32'd1);
    check("s5_req1_waiting", 32'(req_valid[1]), 32'd1);
    tick(); out_ready = 1'b1;
    sample(); h = cyc_now;
    n = 0;
    while (!req_ready[1] && n < 30) begin sample(); n++; end
    check("s5_regrant_delay", cyc_now - h, 32'd3);
    hs_target += 2; wait_hs(hs_target);

    // Reset during ACCUM after two beats, then a full resend
    tick();
    e0 = ena_cnt;
    push_beat(0, 32'h3F800000, 1'b0, 0);
    push_beat(0, 32'h3F800000, 1'b0, 0);
    push_beat(0, 32'h3F800000, 1'b1, 10);
    n = 0;
    while (ena_cnt - e0 < 2 && n < 50) begin sample(); n++; end
    check("s6_two_beats", ena_cnt - e0, 32'd2);
    tick(); rst = 1'b1;
    sample();
    check("s6_clr_in_reset", 32'(acc_clr), 32'd1);
    check("s6_ready_in_reset", 32'(req_ready), 32'd0);
    tick(); rst = 1'b0;
    sample();
    check("s6_busy_after", 32'(busy), 32'd0);
    check("s6_out_valid_after", 32'(out_valid), 32'd0);
    check("s6_out_data_after", out_data, 32'h0);
    tick();
    push_beat(0, 32'h3F800000, 1'b0, 0);
    push_beat(0, 32'h3F800000, 1'b0, 0);
    push_beat(0, 32'h3F800000, 1'b1, 0);
    push_exp(32'h40400000, 2'd0);
    hs_target += 1; wait_hs(hs_target);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp_acc_arbiter.md
Name: fp_acc_arbiter

Overview:
- Shares one single-precision floating-point accumulator (FP_ACC-style: ax input, result fed back to ay, clr, ena) among NUM_REQ force-pipeline requesters.
- Each requester streams a burst of partial values terminated by a last flag. The block grants bursts round-robin, feeds the accumulator, and waits out the accumulator latency.
- It then returns the sum tagged with the requester id and clears the accumulator before the next burst.
- Sits between the range-limited force pipelines and the force cache write-back.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of out_id; must equal clog2(NUM_REQ).
- ACC_LATENCY, 3, cycles from the cycle the final beat is presented on acc_ax with acc_ena=1 until acc_result holds the complete sum (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  32*NUM_REQ  per-requester fp32 beat, requester i at bits [32i+31:32i].
- req_last  in  NUM_REQ  beat is the final one of the burst.
- req_ready  out  NUM_REQ  beat accepted when valid&ready.
- acc_ax  out  32  accumulator operand.
- acc_ena  out  1  accumulator enable.
- acc_clr  out  1  accumulator clear.
- acc_result  in  32  accumulator running sum.
- out_valid  out  1  result available.
- out_data  out  32  fp32 sum of the burst.
- out_id  out  ID_WIDTH  requester that produced out_data.
- out_ready  in  1  downstream accepts result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge), including mid-operation:
  - state=IDLE, rr_ptr=0, grant=0, drain counter=0, out_valid=0, out_data=0, out_id=0.
  - acc_clr=1 combinationally while rst is high; req_ready=0.
  - Any in-flight burst is discarded; the requester must re-send it.
- States:
  - IDLE: if any req_valid, grant := first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; go to ACCUM next cycle. No ready is given in IDLE, so the first beat is accepted no earlier than the following cycle.
  - ACCUM:
    - req_ready[grant]=1 (combinational); all other bits 0.
    - acc_ax=req_data[grant]; acc_ena=req_valid[grant].
    - If the granted valid drops mid-burst, acc_ena=0 and the sum is held.
    - Valid beats from non-granted requesters are ignored; they wait.
    - When a beat with req_last is accepted, go to DRAIN with counter := ACC_LATENCY-1.
  - DRAIN:
    - acc_ena=0.
    - If counter==0: capture out_data := acc_result, out_id := grant, out_valid := 1, go to OUTPUT. Otherwise decrement the counter.
    - With ACC_LATENCY=1, capture happens on the first DRAIN cycle.
  - OUTPUT:
    - out_valid=1; out_data and out_id are held stable.
    - When out_valid&out_ready: out_valid := 0, go to CLEAR.
    - While out_ready=0, stay indefinitely; no new grants are made.
  - CLEAR:
    - acc_clr=1 and acc_ena=0 for exactly one cycle.
    - rr_ptr := (grant+1) mod NUM_REQ.
    - Go to IDLE.
- acc_ax = 0 whenever state != ACCUM.
- Outside ACCUM, acc_ena=0.
- Outside CLEAR (and reset), acc_clr=0.
- Single-beat burst (valid+last on the first accepted beat) is legal.
- No arithmetic is done in the block; values pass through bit-exact.
- Minimum cycles per burst of N beats with no stalls: 1 (IDLE) + N + ACC_LATENCY (DRAIN) + 1 (OUTPUT, out_ready=1) + 1 (CLEAR).
- Fairness: a requester asserting valid continuously is granted within NUM_REQ-1 bursts.

Test Plan:
- ACC_LATENCY=3 with a behavioural accumulator model. Requester 1 sends 0x3F800000, 0x40000000, then 0x40400000 with last, no gaps, out_ready=1.
  - Response: one out_valid pulse with out_data=0x40C00000 (6.0) and out_id=1.
  - acc_clr high for exactly one cycle after the handshake.
  - out_valid rises 4 cycles after the last-beat cycle.
- Requesters 0 and 2 both valid from reset, each sending a 2-beat burst of 0x3F800000.
  - Response: results (0x40000000, id 0) then (0x40000000, id 2).
  - req_ready[2]=0 throughout the first burst.
- Requesters 0–3 all continuously valid, single-beat bursts of 0x40800000.
  - Response: ids in order 0, 1, 2, 3, 0, …, each with out_data=0x40800000 (no carry-over between bursts, which proves the clear).
- Requester 3 sends 0x3F800000, drops valid for 5 cycles, then sends 0x3F800000 with last.
  - Response: acc_ena=0 during the gap; result 0x40000000, id 3.
- out_ready held 0 for 10 cycles after out_valid, while requester 1 is valid.
  - Response: out_data and out_id stable; req_ready=0; acc_clr=0.
  - Grant to requester 1 occurs only after the handshake and the CLEAR cycle.
- rst pulsed for one cycle during ACCUM after 2 beats.
  - Response: next cycle state=IDLE, out_valid=0, busy=0, acc_clr was 1 during the reset cycle.
  - A resent 3-beat burst of 0x3F800000 from requester 0 yields 0x40400000, id 0.
